// File: rtl/row_buffer_ctrl.sv
// Sequencing controller for the WIN-row pixel delay line: accepts a raster stream,
// drives the line's ena/pixel inputs, tracks position and flags complete windows.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a start-of-frame pixel, non-sof pixels dropped
// FILL  | writing the first WIN-1 rows, no window can be complete yet
// RUN   | rows WIN-1 and later, windows flagged on qualifying writes
// DONE  | one-cycle frame_done bubble after the last pixel, then IDLE
module row_buffer_ctrl #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int WIN         = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [PIXEL_WIDTH-1:0]   in_pixel,
  output logic                     in_ready,
  input  logic                     ds_ready,
  output logic                     buf_ena,
  output logic [PIXEL_WIDTH-1:0]   buf_pixel,
  output logic                     win_valid,
  output logic [$clog2(IMG_H)-1:0] cen_row,
  output logic [$clog2(IMG_W)-1:0] cen_col,
  output logic                     frame_done,
  output logic                     sof_err
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_WIN  = RW'(WIN - 1);
  localparam logic [CW-1:0] COL_WIN  = CW'(WIN - 1);
  localparam logic [RW-1:0] HALF_R   = RW'((WIN - 1) / 2);
  localparam logic [CW-1:0] HALF_C   = CW'((WIN - 1) / 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          win_valid_q, win_valid_d;
  logic [RW-1:0] cen_row_q, cen_row_d;
  logic [CW-1:0] cen_col_q, cen_col_d;
  logic          sof_err_q, sof_err_d;

  logic          acc;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic          wr_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      win_valid_q <= 1'b0;
      cen_row_q   <= '0;
      cen_col_q   <= '0;
      sof_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      win_valid_q <= win_valid_d;
      cen_row_q   <= cen_row_d;
      cen_col_q   <= cen_col_d;
      sof_err_q   <= sof_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    win_valid_d = 1'b0;
    cen_row_d   = cen_row_q;
    cen_col_d   = cen_col_q;
    sof_err_d   = 1'b0;
    in_ready    = 1'b1;
    acc         = 1'b0;
    buf_ena     = 1'b0;
    wr_row      = '0;
    wr_col      = '0;
    wr_last     = 1'b0;

    case (state_q)
      S_IDLE:         in_ready = 1'b1;
      S_FILL, S_RUN:  in_ready = ds_ready;
      default:        in_ready = 1'b0;
    endcase

    acc     = in_valid & in_ready;
    buf_ena = acc & ((state_q != S_IDLE) | in_sof);

    // A sof pixel always lands at (0,0), mid-frame restarts included.
    wr_row  = in_sof ? '0 : row_q;
    wr_col  = in_sof ? '0 : col_q;
    wr_last = ~in_sof & (wr_row == ROW_LAST) & (wr_col == COL_LAST);

    if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end

    if (buf_ena) begin
      if (wr_col == COL_LAST) begin
        col_d = '0;
        row_d = (wr_row == ROW_LAST) ? '0 : wr_row + RW'(1);
      end else begin
        col_d = wr_col + CW'(1);
        row_d = wr_row;
      end

      if (wr_last) begin
        state_d = S_DONE;
      end else if ((wr_row == ROW_WIN) && (wr_col == '0)) begin
        state_d = S_RUN;
      end else if (in_sof) begin
        state_d = S_FILL;
      end

      sof_err_d = in_sof & ((state_q == S_FILL) | (state_q == S_RUN));

      if ((wr_row >= ROW_WIN) && (wr_col >= COL_WIN)) begin
        win_valid_d = 1'b1;
        cen_row_d   = wr_row - HALF_R;
        cen_col_d   = wr_col - HALF_C;
      end
    end
  end

  assign buf_pixel  = in_pixel;
  assign win_valid  = win_valid_q;
  assign cen_row    = cen_row_q;
  assign cen_col    = cen_col_q;
  assign sof_err    = sof_err_q;
  assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_row_buffer_ctrl.sv
// Randomized bench for row_buffer_ctrl on a 64x48 frame, checked cycle by cycle
// against a linear-index frame model plus a queue-based delay line.
module tb_row_buffer_ctrl;

  localparam int PW   = 8;
  localparam int W    = 64;
  localparam int H    = 48;
  localparam int WIN  = 37;
  localparam int HALF = (WIN - 1) / 2;
  localparam int NPIX = W * H;
  localparam int DL   = (WIN - 1) * W + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_sof;
  logic [PW-1:0] in_pixel;
  logic          in_ready;
  logic          ds_ready;
  logic          buf_ena;
  logic [PW-1:0] buf_pixel;
  logic          win_valid;
  logic [5:0]    cen_row;
  logic [5:0]    cen_col;
  logic          frame_done;
  logic          sof_err;

  always #5 clk = ~clk;

  row_buffer_ctrl #(
    .PIXEL_WIDTH(PW), .IMG_W(W), .IMG_H(H), .WIN(WIN)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .in_pixel(in_pixel), .in_ready(in_ready), .ds_ready(ds_ready),
    .buf_ena(buf_ena), .buf_pixel(buf_pixel), .win_valid(win_valid),
    .cen_row(cen_row), .cen_col(cen_col), .frame_done(frame_done),
    .sof_err(sof_err)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Downstream delay line: newest pixel at the back, oldest tap at the front.
  logic [PW-1:0] dl[$];
  always @(posedge clk) begin
    if (buf_ena) begin
      dl.push_back(buf_pixel);
      if (dl.size() > DL) void'(dl.pop_front());
    end
  end

  // Reference model: frame position as a linear pixel index.
  bit            m_active, m_done;
  int            m_idx;
  bit            e_win, e_serr;
  int            e_cr, e_cc;
  logic [PW-1:0] frame [NPIX];

  // Source and phase control
  int            src_idx;
  logic [PW-1:0] src_pix;
  int            inject_at, rst_at, valid_pct, ready_pct;
  bit            force_rst, junk, chk_reset_next;

  // Per-phase observations
  int n_win, first_cr, first_cc, last_cr, last_cc, n_fd, n_serr, stall_viol;
  int n_sof_wr, since_sof, post_since, post_cr, post_cc, n_post_win;

  task automatic model_reset();
    m_active = 0; m_done = 0; m_idx = 0;
    e_win = 0; e_serr = 0; e_cr = 0; e_cc = 0;
  endtask

  task automatic cycle();
    bit exp_ready, exp_acc, exp_wr, do_rst, present, n_done;
    int idx, r, c;
    @(negedge clk);
    do_rst   = force_rst;
    if (inject_at >= 0 && src_idx == inject_at) begin
      src_idx   = 0;
      inject_at = -1;
    end
    present  = (src_idx < NPIX);
    in_valid = present && ($urandom_range(99) < valid_pct);
    in_sof   = present && (src_idx == 0);
    in_pixel = src_pix;
    if (junk) begin
      in_valid = 1'b1;
      in_sof   = 1'b0;
    end
    if (rst_at >= 0 && src_idx == rst_at) begin
      do_rst  = 1;
      rst_at  = -1;
      src_idx = NPIX;
    end
    rst      = do_rst;
    ds_ready = ($urandom_range(99) < ready_pct);
    #1;

    exp_ready = m_done ? 1'b0 : (m_active ? ds_ready : 1'b1);
    exp_acc   = in_valid & exp_ready;
    exp_wr    = exp_acc & (m_active | in_sof);

    chk("in_ready", in_ready, exp_ready);
    chk("buf_ena", buf_ena, exp_wr);
    chk("buf_pixel", buf_pixel, in_pixel);
    chk("win_valid", win_valid, e_win);
    chk("cen_row", cen_row, e_cr);
    chk("cen_col", cen_col, e_cc);
    chk("frame_done", frame_done, m_done);
    chk("sof_err", sof_err, e_serr);
    if (junk) chk("idle_ena", buf_ena, 0);

    if (chk_reset_next) begin
      chk("rst_win_valid", win_valid, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_sof_err", sof_err, 0);
      chk("rst_cen", {cen_row, cen_col}, 0);
      chk("rst_in_ready", in_ready, 1);
      chk_reset_next = 0;
    end

    if (win_valid) begin
      n_win++;
      if (n_win == 1) begin first_cr = cen_row; first_cc = cen_col; end
      last_cr = cen_row; last_cc = cen_col;
      r = cen_row + HALF;
      c = cen_col + HALF;
      chk("dl_depth", dl.size(), DL);
      if (dl.size() == DL && r < H && c < W) begin
        chk("tap_e37", dl[DL-1], frame[r*W + c]);
        chk("tap_e1", dl[0], frame[(r-(WIN-1))*W + c]);
      end
      if (n_sof_wr >= 2) begin
        n_post_win++;
        if (post_since < 0) begin
          post_since = since_sof; post_cr = cen_row; post_cc = cen_col;
        end
      end
    end
    if (frame_done) begin
      n_fd++;
      chk("fd_writes", since_sof, NPIX);
    end
    if (sof_err) n_serr++;
    if (buf_ena && !ds_ready) stall_viol++;
    if (buf_ena && in_sof) begin
      n_sof_wr++;
      since_sof = 1;
    end else if (buf_ena) begin
      since_sof++;
    end

    if (do_rst) begin
      model_reset();
      chk_reset_next = 1;
    end else begin
      e_win  = 0;
      e_serr = 0;
      n_done = 0;
      if (m_done) m_active = 0;
      if (exp_wr) begin
        idx = in_sof ? 0 : m_idx;
        frame[idx] = in_pixel;
        r = idx / W;
        c = idx % W;
        if (r >= WIN-1 && c >= WIN-1) begin
          e_win = 1; e_cr = r - HALF; e_cc = c - HALF;
        end
        e_serr = in_sof & m_active;
        if (!in_sof && idx == NPIX-1) begin
          n_done = 1; m_active = 0; m_idx = 0;
        end else begin
          m_active = 1; m_idx = idx + 1;
        end
      end
      m_done = n_done;
    end
    if (exp_acc && !junk && present) begin
      src_idx++;
      src_pix = PW'($urandom);
    end
  endtask

  task automatic run_phase(input int vpct, input int rpct, input int inj,
                           input int rat, input int max_cyc);
    int tail;
    valid_pct = vpct; ready_pct = rpct; inject_at = inj; rst_at = rat;
    n_win = 0; first_cr = -1; first_cc = -1; last_cr = -1; last_cc = -1;
    n_fd = 0; n_serr = 0; stall_viol = 0; n_sof_wr = 0; since_sof = 0;
    post_since = -1; post_cr = -1; post_cc = -1; n_post_win = 0;
    src_idx = 0; src_pix = PW'($urandom);
    tail = 0;
    for (int k = 0; k < max_cyc; k++) begin
      cycle();
      if (src_idx >= NPIX && !m_active && !m_done) tail++;
      if (tail >= 4) break;
    end
    if (tail < 4) chk("phase_timeout", 1, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0; ds_ready = 1'b1;
    force_rst = 0; junk = 0; chk_reset_next = 0;
    src_idx = NPIX; src_pix = '0; inject_at = -1; rst_at = -1;
    valid_pct = 100; ready_pct = 100;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset held, then junk non-sof pixels while idle
    force_rst = 1;
    repeat (3) cycle();
    force_rst = 0;
    junk = 1;
    repeat (10) cycle();
    junk = 0;

    // Continuous full frame
    run_phase(100, 100, -1, -1, 5000);
    chk("full_nwin", n_win, 336);
    chk("full_first", {first_cr[15:0], first_cc[15:0]}, {16'd18, 16'd18});
    chk("full_last", {last_cr[15:0], last_cc[15:0]}, {16'd29, 16'd45});
    chk("full_nfd", n_fd, 1);

    // Random source gaps and downstream stalls
    run_phase(85, 50, -1, -1, 30000);
    chk("stall_nwin", n_win, 336);
    chk("stall_first", {first_cr[15:0], first_cc[15:0]}, {16'd18, 16'd18});
    chk("stall_last", {last_cr[15:0], last_cc[15:0]}, {16'd29, 16'd45});
    chk("stall_nfd", n_fd, 1);
    chk("stall_viol", stall_viol, 0);

    // Mid-frame sof at (40,10)
    run_phase(100, 100, 40*W + 10, -1, 10000);
    chk("msof_nserr", n_serr, 1);
    chk("msof_gap", post_since, (WIN-1)*W + (WIN-1) + 1);
    chk("msof_first", {post_cr[15:0], post_cc[15:0]}, {16'd18, 16'd18});
    chk("msof_npost", n_post_win, 336);
    chk("msof_nfd", n_fd, 1);

    // Reset while running at (45,50)
    run_phase(100, 100, -1, 45*W + 50, 5000);
    chk("rrun_nfd", n_fd, 0);
    chk("rrun_nserr", n_serr, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
